// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command frame parser.
// Holds state encodings, opcodes, the default sync marker and the opcode check.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GET_CMD  = 3'd1,
      ST_GET_ADDR = 3'd2,
      ST_GET_DATA = 3'd3,
      ST_GET_CHK  = 3'd4,
      ST_ISSUE    = 3'd5
   } state_e;

   localparam logic [7:0]  OPC_WRITE    = 8'h01;
   localparam logic [7:0]  OPC_READ     = 8'h02;
   localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
   localparam int unsigned TO_CNT_W     = 24;

   function automatic logic opc_valid(input logic [7:0] opc);
      return (opc == OPC_WRITE) || (opc == OPC_READ);
   endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: clears on clr_i, counts while en_i, and flags
// tc_o while enabled and sitting at LIMIT.
module uart_cmd_timeout
   import uart_cmd_pkg::*;
#(
   parameter logic [TO_CNT_W-1:0] LIMIT = 24'd3479
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [TO_CNT_W-1:0] cnt_q;
   logic [TO_CNT_W-1:0] cnt_d;

   // Next count: clear wins, saturate at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 24'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/ADDR/DATA/CHK frames from the UART receiver and issues
// one validated register request per frame over a valid/ack handshake.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT  = 87,
   parameter int unsigned TIMEOUT_BYTES = 4,
   parameter logic [7:0]  SYNC_BYTE     = SYNC_DEFAULT
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   output logic       o_Cmd_Valid,
   output logic       o_Cmd_Write,
   output logic [7:0] o_Cmd_Addr,
   output logic [7:0] o_Cmd_Data,
   input  logic       i_Cmd_Ack,
   output logic       o_Err_Opcode,
   output logic       o_Err_Chk,
   output logic       o_Err_Timeout,
   output logic       o_Err_Overrun,
   output logic       o_Busy
);

   localparam int unsigned TO_LIMIT_INT = TIMEOUT_BYTES * 32'd10 * CLKS_PER_BIT - 32'd1;
   localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_LIMIT_INT[TO_CNT_W-1:0];

   state_e     state_q, state_d;
   logic       write_q, write_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic [7:0] xor_q, xor_d;
   logic       valid_q, busy_q;
   logic       err_opc_q, err_opc_d;
   logic       err_chk_q, err_chk_d;
   logic       err_to_q, err_to_d;
   logic       err_ovr_q, err_ovr_d;
   logic       timed_s, to_clr_s, to_tc_s;

   assign timed_s  = (state_q == ST_GET_CMD) || (state_q == ST_GET_ADDR) ||
                     (state_q == ST_GET_DATA) || (state_q == ST_GET_CHK);
   assign to_clr_s = i_Rx_DV || (state_d != state_q) || !timed_s;

   uart_cmd_timeout #(.LIMIT(TO_LIMIT)) u_timeout (
      .clk_i (i_Clock),
      .rst_i (i_Reset),
      .clr_i (to_clr_s),
      .en_i  (timed_s),
      .tc_o  (to_tc_s)
   );

   // Frame FSM: a received byte takes priority over a coincident timeout.
   always_comb begin
      state_d   = state_q;
      write_d   = write_q;
      addr_d    = addr_q;
      data_d    = data_q;
      xor_d     = xor_q;
      err_opc_d = 1'b0;
      err_chk_d = 1'b0;
      err_to_d  = 1'b0;
      err_ovr_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
               state_d = ST_GET_CMD;
               xor_d   = 8'h00;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GET_CMD: begin
            if (i_Rx_DV) begin
               if (opc_valid(i_Rx_Byte)) begin
                  write_d = (i_Rx_Byte == OPC_WRITE);
                  xor_d   = xor_q ^ i_Rx_Byte;
                  state_d = ST_GET_ADDR;
               end else begin
                  err_opc_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end else if (to_tc_s) begin
               err_to_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_GET_CMD;
            end
         end
         ST_GET_ADDR: begin
            if (i_Rx_DV) begin
               addr_d  = i_Rx_Byte;
               xor_d   = xor_q ^ i_Rx_Byte;
               state_d = ST_GET_DATA;
            end else if (to_tc_s) begin
               err_to_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_GET_ADDR;
            end
         end
         ST_GET_DATA: begin
            if (i_Rx_DV) begin
               data_d  = i_Rx_Byte;
               xor_d   = xor_q ^ i_Rx_Byte;
               state_d = ST_GET_CHK;
            end else if (to_tc_s) begin
               err_to_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_GET_DATA;
            end
         end
         ST_GET_CHK: begin
            if (i_Rx_DV) begin
               if (i_Rx_Byte == xor_q) begin
                  state_d = ST_ISSUE;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end else if (to_tc_s) begin
               err_to_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_GET_CHK;
            end
         end
         ST_ISSUE: begin
            // Any byte here is dropped, even a SYNC on the ack cycle.
            err_ovr_d = i_Rx_DV;
            if (i_Cmd_Ack) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched fields and registered outputs.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= ST_IDLE;
         write_q   <= 1'b0;
         addr_q    <= 8'h00;
         data_q    <= 8'h00;
         xor_q     <= 8'h00;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_opc_q <= 1'b0;
         err_chk_q <= 1'b0;
         err_to_q  <= 1'b0;
         err_ovr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         xor_q     <= xor_d;
         valid_q   <= (state_d == ST_ISSUE);
         busy_q    <= (state_d != ST_IDLE);
         err_opc_q <= err_opc_d;
         err_chk_q <= err_chk_d;
         err_to_q  <= err_to_d;
         err_ovr_q <= err_ovr_d;
      end
   end

   assign o_Cmd_Valid   = valid_q;
   assign o_Cmd_Write   = write_q;
   assign o_Cmd_Addr    = addr_q;
   assign o_Cmd_Data    = data_q;
   assign o_Err_Opcode  = err_opc_q;
   assign o_Err_Chk     = err_chk_q;
   assign o_Err_Timeout = err_to_q;
   assign o_Err_Overrun = err_ovr_q;
   assign o_Busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and randomized frame checks for uart_cmd_parser against a
// frame-level reference model.
module tb_uart_cmd_parser;

   logic       clk = 1'b0;
   logic       rst;
   logic       dv;
   logic [7:0] rxb;
   logic       ack;
   logic       o_valid, o_write, o_eopc, o_echk, o_eto, o_eovr, o_busy;
   logic [7:0] o_addr, o_data;

   int total = 0;
   int bad   = 0;
   int n_opc = 0, n_chk = 0, n_to = 0, n_ovr = 0, n_rise = 0;
   int e_opc = 0, e_chk = 0, e_to = 0, e_ovr = 0, e_rise = 0;
   logic valid_prev = 1'b0;

   uart_cmd_parser dut (
      .i_Clock       (clk),
      .i_Reset       (rst),
      .i_Rx_DV       (dv),
      .i_Rx_Byte     (rxb),
      .o_Cmd_Valid   (o_valid),
      .o_Cmd_Write   (o_write),
      .o_Cmd_Addr    (o_addr),
      .o_Cmd_Data    (o_data),
      .i_Cmd_Ack     (ack),
      .o_Err_Opcode  (o_eopc),
      .o_Err_Chk     (o_echk),
      .o_Err_Timeout (o_eto),
      .o_Err_Overrun (o_eovr),
      .o_Busy        (o_busy)
   );

   always #5 clk = ~clk;

   // Pulse / rising-edge counters sampled on the falling edge.
   always @(negedge clk) begin
      if (o_eopc) n_opc <= n_opc + 1;
      if (o_echk) n_chk <= n_chk + 1;
      if (o_eto)  n_to  <= n_to + 1;
      if (o_eovr) n_ovr <= n_ovr + 1;
      if (o_valid && !valid_prev) n_rise <= n_rise + 1;
      valid_prev <= o_valid;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [22:0] outs();
      return {o_valid, o_write, o_addr, o_data, o_eopc, o_echk, o_eto, o_eovr, o_busy};
   endfunction

   function automatic logic [22:0] ev(input logic v, input logic w, input logic [7:0] a,
                                      input logic [7:0] d, input logic [3:0] errs,
                                      input logic busy);
      return {v, w, a, d, errs, busy};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      dv  = 1'b1;
      rxb = b;
      tick();
      dv  = 1'b0;
   endtask

   initial begin
      int found;
      int sel;
      int dly;
      logic [7:0] cmd, addr, data, chk;
      logic opc_ok;

      rst = 1'b1; dv = 1'b0; ack = 1'b0; rxb = 8'h00;
      repeat (3) tick();
      check("reset_outs", 32'(outs()), 32'(ev(1'b0, 1'b0, 8'h00, 8'h00, 4'b0000, 1'b0)));
      @(negedge clk); rst = 1'b0;
      tick();

      // Write frame, ack after 3 cycles.
      send(8'hA5, 0); send(8'h01, 0); send(8'h10, 0); send(8'h5A, 0);
      check("wr_busy_mid", 32'(o_busy), 32'd1);
      send(8'h4B, 0); e_rise++;
      check("wr_valid", 32'(outs()), 32'(ev(1'b1, 1'b1, 8'h10, 8'h5A, 4'b0000, 1'b1)));
      tick(); tick();
      check("wr_hold", 32'(outs()), 32'(ev(1'b1, 1'b1, 8'h10, 8'h5A, 4'b0000, 1'b1)));
      ack = 1'b1; tick(); ack = 1'b0;
      check("wr_fall", 32'({o_valid, o_busy}), 32'd0);

      // Read frame with ack held high: one-cycle valid.
      ack = 1'b1;
      send(8'hA5, 1); send(8'h02, 0); send(8'h20, 0); send(8'h00, 0); send(8'h22, 0); e_rise++;
      check("rd_valid", 32'(outs()), 32'(ev(1'b1, 1'b0, 8'h20, 8'h00, 4'b0000, 1'b1)));
      tick();
      check("rd_fall", 32'({o_valid, o_busy}), 32'd0);
      ack = 1'b0;

      // Bad checksum, then a good frame.
      send(8'hA5, 1); send(8'h01, 0); send(8'h10, 0); send(8'h5A, 0); send(8'h4C, 0); e_chk++;
      check("chk_pulse", 32'({o_valid, o_echk, o_eopc, o_eto, o_eovr, o_busy}), 32'b010000);
      tick();
      check("chk_width", 32'(o_echk), 32'd0);
      send(8'hA5, 0); send(8'h02, 0); send(8'h33, 0); send(8'h44, 0); send(8'h75, 0); e_rise++;
      check("after_chk_valid", 32'(outs()), 32'(ev(1'b1, 1'b0, 8'h33, 8'h44, 4'b0000, 1'b1)));
      ack = 1'b1; tick(); ack = 1'b0;

      // Noise in idle, then bad opcode; trailing bytes ignored.
      send(8'h33, 1);
      check("noise_idle", 32'({o_busy, o_eopc, o_echk, o_eto, o_eovr}), 32'd0);
      send(8'hA5, 0); send(8'h07, 0); e_opc++;
      check("opc_pulse", 32'({o_valid, o_eopc, o_echk, o_eto, o_eovr, o_busy}), 32'b010000);
      tick();
      check("opc_width", 32'(o_eopc), 32'd0);
      send(8'h10, 0); send(8'h5A, 0); send(8'h4B, 0); tick();
      check("opc_ignored", 32'({o_busy, o_valid}), 32'd0);

      // Timeout: pulse 3480 clocks after the opcode strobe.
      send(8'hA5, 0); send(8'h01, 0);
      found = 0;
      for (int k = 1; k <= 4000; k++) begin
         tick();
         if (o_eto) begin
            found = k;
            break;
         end
      end
      e_to++;
      check("timeout_clks", 32'(found), 32'd3480);
      check("timeout_idle", 32'({o_busy, o_valid}), 32'd0);

      // Overrun during ISSUE; the dropped SYNC must not start a frame.
      send(8'hA5, 0); send(8'h01, 0); send(8'h40, 0); send(8'h77, 0); send(8'h36, 0); e_rise++;
      send(8'hA5, 1); e_ovr++;
      check("ovr_pulse", 32'(outs()), 32'(ev(1'b1, 1'b1, 8'h40, 8'h77, 4'b0001, 1'b1)));
      tick();
      check("ovr_width", 32'(outs()), 32'(ev(1'b1, 1'b1, 8'h40, 8'h77, 4'b0000, 1'b1)));
      ack = 1'b1; tick(); ack = 1'b0;
      send(8'h01, 0); send(8'h40, 0); send(8'h77, 0); send(8'h36, 0); tick();
      check("ovr_sync_dropped", 32'({o_busy, o_valid}), 32'd0);

      // SYNC on the very cycle ack is sampled is an overrun.
      send(8'hA5, 0); send(8'h02, 0); send(8'h01, 0); send(8'h02, 0); send(8'h01, 0); e_rise++;
      ack = 1'b1; dv = 1'b1; rxb = 8'hA5; tick(); ack = 1'b0; dv = 1'b0; e_ovr++;
      check("ack_sync_ovr", 32'({o_valid, o_eovr, o_busy}), 32'b010);
      tick();
      check("ack_sync_idle", 32'({o_valid, o_eovr, o_busy}), 32'b000);

      // Asynchronous reset mid-frame, then a fresh frame.
      send(8'hA5, 0); send(8'h01, 0);
      check("pre_rst_busy", 32'(o_busy), 32'd1);
      rst = 1'b1; #1;
      check("async_rst", 32'(outs()), 32'(ev(1'b0, 1'b0, 8'h00, 8'h00, 4'b0000, 1'b0)));
      @(negedge clk); rst = 1'b0;
      tick();
      send(8'hA5, 0); send(8'h02, 0); send(8'h55, 0); send(8'h66, 0); send(8'h31, 0); e_rise++;
      check("post_rst_valid", 32'(outs()), 32'(ev(1'b1, 1'b0, 8'h55, 8'h66, 4'b0000, 1'b1)));
      ack = 1'b1; tick(); ack = 1'b0;

      // Randomized frames against the frame-level model.
      for (int i = 0; i < 24; i++) begin
         sel  = $urandom_range(0, 3);
         cmd  = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h02 : 8'($urandom_range(0, 255));
         addr = 8'($urandom_range(0, 255));
         data = 8'($urandom_range(0, 255));
         chk  = cmd ^ addr ^ data;
         if ($urandom_range(0, 3) == 0) chk = chk ^ (8'd1 << $urandom_range(0, 7));
         opc_ok = (cmd == 8'h01) || (cmd == 8'h02);
         send(8'hA5, $urandom_range(0, 3));
         send(cmd, $urandom_range(0, 3));
         if (!opc_ok) begin
            e_opc++;
            check("rnd_opc", 32'({o_eopc, o_busy, o_valid}), 32'b100);
            tick();
            continue;
         end
         send(addr, $urandom_range(0, 3));
         send(data, $urandom_range(0, 3));
         send(chk, $urandom_range(0, 3));
         if (chk != (cmd ^ addr ^ data)) begin
            e_chk++;
            check("rnd_chk", 32'({o_echk, o_busy, o_valid}), 32'b100);
         end else begin
            e_rise++;
            check("rnd_valid", 32'(outs()),
                  32'(ev(1'b1, cmd == 8'h01, addr, data, 4'b0000, 1'b1)));
            dly = $urandom_range(0, 4);
            repeat (dly) tick();
            check("rnd_hold", 32'({o_valid, o_write, o_addr, o_data}),
                  32'({1'b1, cmd == 8'h01, addr, data}));
            ack = 1'b1; tick(); ack = 1'b0;
            check("rnd_fall", 32'({o_valid, o_busy}), 32'd0);
         end
         tick();
      end

      tick(); tick();
      check("cnt_opc", 32'(n_opc), 32'(e_opc));
      check("cnt_chk", 32'(n_chk), 32'(e_chk));
      check("cnt_to", 32'(n_to), 32'(e_to));
      check("cnt_ovr", 32'(n_ovr), 32'(e_ovr));
      check("cnt_rise", 32'(n_rise), 32'(e_rise));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
